// File: rtl/div_unit_pkg.sv
// Shared constants for the EX-stage integer divider: reset level,
// handshake levels, bus widths and the divider FSM state encodings.
// Ports: none (package only).
package div_unit_pkg;

  // Reset is asserted low.
  localparam logic RstEnable         = 1'b0;

  // Handshake levels.
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;

  // Bus widths.
  localparam int   RegBus            = 32;
  localparam int   DoubleRegBus      = 2 * RegBus;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  // Divider control states.
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result {rem, quot} for HI/LO.
// Latency: ready_o high after the 34th edge from start (WIDTH=32), 2nd edge on divide-by-zero.
// Backpressure: result held while start_i stays high; start_i low or annul_i returns to FREE.
// Ports:
//   clk, rst (async, active low)
//   signed_div_i, opdata1_i (dividend), opdata2_i (divisor), start_i, annul_i
//   result_o = {remainder, quotient}, ready_o = result valid
module div_unit
  import div_unit_pkg::*;
#(
  parameter int WIDTH = RegBus
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // Registers
  div_state_e           r_state;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH:0]     r_work;      // {partial remainder (WIDTH+1), dividend/quotient (WIDTH)}
  logic [WIDTH-1:0]     r_divisor;   // divisor magnitude
  logic                 r_neg_quot;
  logic                 r_neg_rem;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_ready;

  // Next-state values
  div_state_e           w_state_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [2*WIDTH:0]     w_work_nxt;
  logic [WIDTH-1:0]     w_divisor_nxt;
  logic                 w_neg_quot_nxt;
  logic                 w_neg_rem_nxt;
  logic [2*WIDTH-1:0]   w_result_nxt;
  logic                 w_ready_nxt;

  // Operand magnitudes (only meaningful while loading in FREE)
  logic                 w_op1_neg;
  logic                 w_op2_neg;
  logic [WIDTH-1:0]     w_op1_mag;
  logic [WIDTH-1:0]     w_op2_mag;

  // Restoring step datapath
  logic [2*WIDTH:0]     w_shift;
  logic [WIDTH+1:0]     w_diff;
  logic [2*WIDTH:0]     w_step;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_quot_fix;
  logic [WIDTH-1:0]     w_rem_fix;
  logic                 w_unused;

  assign w_op1_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign w_op2_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign w_op1_mag = w_op1_neg ? -opdata1_i : opdata1_i;
  assign w_op2_mag = w_op2_neg ? -opdata2_i : opdata2_i;

  // The partial remainder stays below the divisor, so the top work bit is
  // always zero before the shift and nothing is lost by dropping it.
  assign w_shift = {r_work[2*WIDTH-1:0], 1'b0};
  // One extra bit so the borrow shows up as the sign of the difference.
  assign w_diff  = {1'b0, w_shift[2*WIDTH:WIDTH]} - {2'b00, r_divisor};
  assign w_step  = w_diff[WIDTH+1]
                 ? w_shift                                            // restore, quotient bit 0
                 : {w_diff[WIDTH:0], w_shift[WIDTH-1:1], 1'b1};       // keep, quotient bit 1

  assign w_quot     = r_work[WIDTH-1:0];
  assign w_rem      = r_work[2*WIDTH-1:WIDTH];
  assign w_quot_fix = r_neg_quot ? -w_quot : w_quot;
  assign w_rem_fix  = r_neg_rem  ? -w_rem  : w_rem;

  assign w_unused = r_work[2*WIDTH] ^ w_shift[0];

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_work_nxt     = r_work;
    w_divisor_nxt  = r_divisor;
    w_neg_quot_nxt = r_neg_quot;
    w_neg_rem_nxt  = r_neg_rem;
    w_result_nxt   = r_result;
    w_ready_nxt    = r_ready;

    case (r_state)
      DivFree: begin
        w_ready_nxt  = DivResultNotReady;
        w_result_nxt = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            w_state_nxt = DivByZero;
          end else begin
            w_state_nxt    = DivOn;
            w_cnt_nxt      = '0;
            w_work_nxt     = {{(WIDTH+1){1'b0}}, w_op1_mag};
            w_divisor_nxt  = w_op2_mag;
            w_neg_quot_nxt = w_op1_neg ^ w_op2_neg;
            w_neg_rem_nxt  = w_op1_neg;
          end
        end
      end

      DivByZero: begin
        if (annul_i) begin
          w_state_nxt = DivFree;
        end else begin
          w_state_nxt  = DivEnd;
          w_result_nxt = '0;
          w_ready_nxt  = DivResultReady;
        end
      end

      DivOn: begin
        if (annul_i) begin
          w_state_nxt = DivFree;
          w_work_nxt  = '0;
          w_cnt_nxt   = '0;
        end else if (r_cnt != CNT_DONE) begin
          w_work_nxt = w_step;
          w_cnt_nxt  = r_cnt + CNT_ONE;
        end else begin
          w_result_nxt = {w_rem_fix, w_quot_fix};
          w_ready_nxt  = DivResultReady;
          w_state_nxt  = DivEnd;
        end
      end

      DivEnd: begin
        if (start_i == DivStop || annul_i) begin
          w_state_nxt  = DivFree;
          w_ready_nxt  = DivResultNotReady;
          w_result_nxt = '0;
        end
      end

      default: begin
        w_state_nxt = DivFree;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      r_state    <= DivFree;
      r_cnt      <= '0;
      r_work     <= '0;
      r_divisor  <= '0;
      r_neg_quot <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_result   <= '0;
      r_ready    <= DivResultNotReady;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_work     <= w_work_nxt;
      r_divisor  <= w_divisor_nxt;
      r_neg_quot <= w_neg_quot_nxt;
      r_neg_rem  <= w_neg_rem_nxt;
      r_result   <= w_result_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign result_o = r_result;
  assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: latency, signed/unsigned
// results, divide-by-zero, annul and asynchronous reset.
// Ports: none (top-level bench).
module tb_div_unit;
  import div_unit_pkg::*;

  logic                      clk;
  logic                      rst;
  logic                      signed_div_i;
  logic [RegBus-1:0]         opdata1_i;
  logic [RegBus-1:0]         opdata2_i;
  logic                      start_i;
  logic                      annul_i;
  logic [DoubleRegBus-1:0]   result_o;
  logic                      ready_o;

  int n_checks;
  int n_errors;

  div_unit #(.WIDTH(RegBus)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one operation with start held, checks the exact ready edge,
  // result hold, and the clear after start drops. lat = edge count to ready.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat);
    @(negedge clk);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    @(posedge clk);                          // E1
    #1;
    opdata1_i    = ~a;                       // later operand changes must be ignored
    opdata2_i    = ~b;
    signed_div_i = ~sgn;
    repeat (lat - 2) @(posedge clk);
    #1 check_eq({tag, "_early"}, {63'd0, ready_o}, 64'd0);
    @(posedge clk);                          // E(lat)
    #1 check_eq({tag, "_rdy"}, {63'd0, ready_o}, 64'd1);
    check_eq({tag, "_res"}, result_o, exp);
    @(posedge clk);
    #1 check_eq({tag, "_hold"}, result_o, exp);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1 check_eq({tag, "_clr"}, {ready_o, result_o[62:0]}, 64'd0);
  endtask

  initial begin
    bit seen_ready;
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;

    #12;
    check_eq("reset_rdy", {63'd0, ready_o}, 64'd0);
    check_eq("reset_res", result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    do_div("divu_7_2",    1'b0, 32'd7,          32'd2,          64'h00000001_00000003, 34);
    do_div("div_m7_2",    1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 34);
    do_div("div_7_m2",    1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 34);
    do_div("div_m7_m2",   1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   64'hFFFFFFFF_00000003, 34);
    do_div("divu_big_2",  1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 34);
    do_div("div_ovf",     1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 34);
    do_div("divu_max_1",  1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 34);
    do_div("divu_zero",   1'b0, 32'd123,        32'd0,          64'd0,                 2);
    do_div("div_zero",    1'b1, 32'hFFFFFF00,   32'd0,          64'd0,                 2);

    // Annul sampled at E10 while dividing; ready must never rise afterwards.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd50;
    opdata2_i    = 32'd5;
    start_i      = 1'b1;
    repeat (9) @(posedge clk);
    #1;
    annul_i = 1'b1;
    start_i = 1'b0;
    @(posedge clk);                          // E10
    #1;
    annul_i = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (ready_o) seen_ready = 1'b1;
    end
    check_eq("annul_no_rdy", {63'd0, seen_ready}, 64'd0);
    do_div("after_annul", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 34);

    // Asynchronous reset in the middle of a division (E20).
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd1000;
    opdata2_i    = 32'd3;
    start_i      = 1'b1;
    repeat (20) @(posedge clk);
    #2 rst = 1'b0;
    #1 check_eq("arst_mid", {ready_o, result_o[62:0]}, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_div("after_rst", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 34);

    // Asynchronous reset while a result is being held: outputs drop between edges.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd20;
    opdata2_i    = 32'd6;
    start_i      = 1'b1;
    repeat (34) @(posedge clk);
    #1 check_eq("end_rdy", {63'd0, ready_o}, 64'd1);
    check_eq("end_res", result_o, 64'h00000002_00000003);
    #2 rst = 1'b0;
    #1 check_eq("arst_end", {ready_o, result_o[62:0]}, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_eq("post_rst_idle", {ready_o, result_o[62:0]}, 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
